xfr_buf_write_arbiter: RTL

//  Round-robin burst arbiter sharing the transmitter write port of the bus-transfer buffer among NUM_REQ requesters.

---
 rtl/xfr_buf_write_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/xfr_buf_write_arbiter.sv
// xfr_buf_write_arbiter: round-robin burst arbiter for the transfer-buffer write port with occupancy tracking.
// Define XFR_ARB_ASSERT_EN to compile in the embedded SVA checks.
module xfr_buf_write_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 32,
    parameter int MAX_BUFF_SIZE = 1024,
    parameter int BURST_LEN     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ*DATA_W-1:0]              req_data,
    output logic [NUM_REQ-1:0]                     gnt,
    output logic                                   buf_wr,
    output logic [DATA_W-1:0]                      buf_wdata,
    input  logic                                   buf_rd_done,
    input  logic                                   flush,
    output logic [$clog2(MAX_BUFF_SIZE+1)-1:0]     buf_count,
    output logic                                   buf_full,
    output logic                                   buf_empty,
    output logic                                   underflow_err
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int CW = $clog2(MAX_BUFF_SIZE + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, pick, cand;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic          pick_vld, last_beat, pop;

    assign buf_full  = buf_count == CW'(MAX_BUFF_SIZE);
    assign buf_empty = buf_count == '0;
    assign pop       = buf_rd_done && !buf_empty;
    assign last_beat = buf_wr && beat_cnt == BW'(BURST_LEN - 1);

    // Scan downward so the lowest cyclic offset from rr_ptr wins.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            buf_count     <= '0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            rr_ptr        <= rr_ptr_nxt;
            beat_cnt      <= beat_cnt_nxt;
            buf_count     <= flush ? '0 : buf_count + CW'(buf_wr) - CW'(pop);
            underflow_err <= underflow_err | (buf_rd_done & buf_empty);
        end
    end

    // A flush abandons the burst without advancing the rotation pointer.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        if (flush)
            state_nxt = IDLE;
        else if (state == IDLE) begin
            if (pick_vld && !buf_full) begin
                state_nxt    = BURST;
                owner_nxt    = pick;
                beat_cnt_nxt = '0;
            end
        end else if (last_beat || !req[owner] || buf_full) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
        end else if (buf_wr)
            beat_cnt_nxt = beat_cnt + 1'b1;
    end

    always_comb begin
        gnt        = '0;
        gnt[owner] = !reset && state == BURST && req[owner] && !buf_full && !flush;
        buf_wr     = |gnt;
        buf_wdata  = buf_wr ? req_data[owner*DATA_W +: DATA_W] : '0;
    end

`ifdef XFR_ARB_ASSERT_EN
    a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_no_full_wr: assert property (@(posedge clk) disable iff (reset) !(buf_wr && buf_full));
    a_gnt_req: assert property (@(posedge clk) disable iff (reset) (gnt & ~req) == '0);
    a_count: assert property (@(posedge clk) disable iff (reset) buf_count <= CW'(MAX_BUFF_SIZE));
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_live
        a_live: assert property (@(posedge clk) disable iff (reset)
            req[i] && !gnt[i] |-> ##[1:NUM_REQ*(BURST_LEN+1)] (gnt[i] || !req[i] || buf_full || flush));
    end
`endif
endmodule
